// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multi-cycle multiply/divide sequencer:
// FSM state encoding, M-op funct3 codes and the operand signedness decode.
package muldiv_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // funct3 codes of the M extension
    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    // Whether each operand is interpreted as two's complement
    typedef struct packed {
        logic signed1;
        logic signed2;
    } md_sign_t;

    function automatic md_sign_t decode_signs(input logic [2:0] f3);
        md_sign_t s;
        s = '0;
        case (f3)
            INST_MUL, INST_MULH, INST_DIV, INST_REM: begin
                s.signed1 = 1'b1;
                s.signed2 = 1'b1;
            end
            INST_MULHSU: s.signed1 = 1'b1;
            default:     s = '0;
        endcase
        return s;
    endfunction

    // Divide ops live in the upper half of the funct3 space
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between exe and the multiply/divide sequencer.
// master = exe side, slave = sequencer side.
interface muldiv_seq_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  req_i;
    logic [2:0]            funct3_i;
    logic [DATA_WIDTH-1:0] rs1_i;
    logic [DATA_WIDTH-1:0] rs2_i;
    logic [4:0]            rd_i;
    logic                  flush_i;
    logic                  stallreq_o;
    logic                  result_valid_o;
    logic [DATA_WIDTH-1:0] result_o;
    logic [4:0]            rd_o;

    modport master (
        output req_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i,
        input  stallreq_o, result_valid_o, result_o, rd_o
    );

    modport slave (
        input  req_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i,
        output stallreq_o, result_valid_o, result_o, rd_o
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned datapath: shift-add multiply into a 2W-bit product, or
// restoring division producing one quotient bit per step. Works on magnitudes;
// sign fix-up is done by the sequencer.
module muldiv_iter #(
    parameter int W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic           is_div_i,
    input  logic [W-1:0]   mag1_i,
    input  logic [W-1:0]   mag2_i,
    output logic [2*W-1:0] product_o,
    output logic [W-1:0]   quotient_o,
    output logic [W-1:0]   remainder_o
);
    // Multiply: acc = {partial high, multiplier being shifted out}, op = multiplicand.
    // Divide:   acc[W-1:0] = partial remainder, shift = dividend -> quotient, op = divisor.
    logic [2*W-1:0] acc_q,    acc_d;
    logic [W-1:0]   shift_q,  shift_d;
    logic [W-1:0]   op_q,     op_d;
    logic           is_div_q, is_div_d;

    logic [W:0]     mul_sum;
    logic [W:0]     rem_sh;
    logic [W:0]     trial;
    logic           fits;

    assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, op_q} : '0);
    assign rem_sh  = {acc_q[W-1:0], shift_q[W-1]};
    assign trial   = rem_sh - {1'b0, op_q};
    assign fits    = (rem_sh >= {1'b0, op_q});

    // Next-state for load and single-step of the datapath
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        acc_d    = acc_q;
        shift_d  = shift_q;
        op_d     = op_q;
        is_div_d = is_div_q;
        if (load_i) begin
            is_div_d = is_div_i;
            shift_d  = mag1_i;
            op_d     = is_div_i ? mag2_i : mag1_i;
            acc_d    = is_div_i ? '0 : {{W{1'b0}}, mag2_i};
        end else if (step_i) begin
            if (is_div_q) begin
                acc_d   = {{W{1'b0}}, (fits ? trial[W-1:0] : rem_sh[W-1:0])};
                shift_d = {shift_q[W-2:0], fits};
            end else begin
                acc_d   = {mul_sum, acc_q[W-1:1]};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            acc_q    <= '0;
            shift_q  <= '0;
            op_q     <= '0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            shift_q  <= shift_d;
            op_q     <= op_d;
            is_div_q <= is_div_d;
        end
    end

    assign product_o   = acc_q;
    assign quotient_o  = shift_q;
    assign remainder_o = acc_q[W-1:0];

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle sequencer. Captures operands from exe, runs DATA_WIDTH
// datapath steps while stalling the pipeline, then returns one result beat.
// Divide-by-zero and signed overflow are resolved at capture.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    muldiv_seq_if.slave md
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);
    localparam logic [W-1:0]     MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]     ALL_ONES = '1;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Captured instruction context
    logic [2:0]   funct3_q;
    logic [4:0]   rd_q;
    logic         sign1_q;
    logic         neg_q;
    logic         special_q;
    logic [W-1:0] special_val_q;

    // Last delivered beat, held while no beat is present
    logic [W-1:0] result_hold_q;
    logic [4:0]   rd_hold_q;

    // Request decode
    md_sign_t     signs;
    logic         sign1, sign2;
    logic [W-1:0] mag1, mag2;
    logic         capture;
    logic         div_now, rem_now, div_zero, div_ovf, special_now;
    logic [W-1:0] special_val;

    assign signs   = decode_signs(md.funct3_i);
    assign sign1   = signs.signed1 & md.rs1_i[W-1];
    assign sign2   = signs.signed2 & md.rs2_i[W-1];
    assign mag1    = sign1 ? -md.rs1_i : md.rs1_i;
    assign mag2    = sign2 ? -md.rs2_i : md.rs2_i;
    assign capture = (state_q == MD_IDLE) && md.req_i && !md.flush_i;

    assign div_now     = is_div_op(md.funct3_i);
    assign rem_now     = md.funct3_i[1];
    assign div_zero    = div_now && (md.rs2_i == '0);
    assign div_ovf     = div_now && signs.signed1 && (md.rs1_i == MIN_NEG) && (md.rs2_i == ALL_ONES);
    assign special_now = div_zero || div_ovf;
    assign special_val = div_zero ? (rem_now ? md.rs1_i : ALL_ONES)
                                  : (rem_now ? '0 : MIN_NEG);

    // Datapath
    logic           step;
    logic [2*W-1:0] product;
    logic [W-1:0]   quotient, remainder;

    muldiv_iter #(.W(W)) u_iter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (capture),
        .step_i      (step),
        .is_div_i    (div_now),
        .mag1_i      (mag1),
        .mag2_i      (mag2),
        .product_o   (product),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    // FSM next-state, step counter and datapath step enable
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        step    = 1'b0;
        if (md.flush_i) begin
            state_d = MD_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md.req_i) begin
                        count_d = '0;
                        state_d = (special_now && FAST_SPECIAL) ? MD_DONE : MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    step = 1'b1;
                    if (count_q == LAST_CNT) begin
                        state_d = MD_DONE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                MD_DONE: state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase
        end
    end

    // FSM state and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MD_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Instruction context captured on an accepted request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            funct3_q      <= '0;
            rd_q          <= '0;
            sign1_q       <= 1'b0;
            neg_q         <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
        end else if (capture) begin
            funct3_q      <= md.funct3_i;
            rd_q          <= md.rd_i;
            sign1_q       <= sign1;
            neg_q         <= sign1 ^ sign2;
            special_q     <= special_now;
            special_val_q <= special_val;
        end
    end

    // Sign fix-up and result select from the finished datapath
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, result_calc, result_now;

    always_comb begin
        prod_fix = neg_q   ? -product   : product;
        quo_fix  = neg_q   ? -quotient  : quotient;
        rem_fix  = sign1_q ? -remainder : remainder;
        case (funct3_q)
            INST_MUL:                            result_calc = prod_fix[W-1:0];
            INST_MULH, INST_MULHSU, INST_MULHU:  result_calc = prod_fix[2*W-1:W];
            INST_DIV, INST_DIVU:                 result_calc = quo_fix;
            INST_REM, INST_REMU:                 result_calc = rem_fix;
            default:                             result_calc = '0;
        endcase
        result_now = special_q ? special_val_q : result_calc;
    end

    // Remember the delivered beat so result_o/rd_o stay stable afterwards
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_hold_q <= '0;
            rd_hold_q     <= '0;
        end else if (state_q == MD_DONE) begin
            result_hold_q <= result_now;
            rd_hold_q     <= rd_q;
        end
    end

    assign md.result_valid_o = (state_q == MD_DONE);
    assign md.result_o       = md.result_valid_o ? result_now : result_hold_q;
    assign md.rd_o           = md.result_valid_o ? rd_q : rd_hold_q;
    assign md.stallreq_o     = !md.flush_i &&
                               (((state_q == MD_IDLE) && md.req_i) || (state_q == MD_BUSY));

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: hand-computed RV32M results,
// latency/stall counts, special cases, flush and reset mid-operation.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    muldiv_seq_if #(.DATA_WIDTH(32)) bus ();

    muldiv_seq #(.DATA_WIDTH(32), .FAST_SPECIAL(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.req_i    = 1'b0;
        bus.funct3_i = 3'b000;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;
        bus.rd_i     = '0;
        bus.flush_i  = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        bus.req_i    = 1'b1;
        bus.funct3_i = f3;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        bus.rd_i     = rd;
        bus.flush_i  = 1'b0;
    endtask

    // Issue one op (held on the inputs like a stalled exe) and check its beat
    task automatic run_vec(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp_res, input int exp_lat);
        int          done_at;
        int          stalls;
        logic [31:0] got;
        logic [4:0]  got_rd;
        done_at = -1;
        stalls  = 0;
        got     = '0;
        got_rd  = '0;
        @(negedge clk);
        drive_req(f3, a, b, rd);
        for (int n = 0; n < 48; n++) begin
            #1;
            if (bus.stallreq_o) stalls++;
            if (bus.result_valid_o) begin
                done_at = n;
                got     = bus.result_o;
                got_rd  = bus.rd_o;
                break;
            end
            @(negedge clk);
        end
        // Inputs still held through the beat; exe moves on in the next cycle
        @(negedge clk);
        drive_idle();
        #1;
        check({tag, "_latency"}, 32'(done_at), 32'(exp_lat));
        check({tag, "_stalls"},  32'(stalls),  32'(exp_lat));
        check({tag, "_result"},  got,          exp_res);
        check({tag, "_rd"},      32'(got_rd),  32'(rd));
        check({tag, "_after_valid"}, 32'(bus.result_valid_o), 32'd0);
        check({tag, "_after_stall"}, 32'(bus.stallreq_o),     32'd0);
        check({tag, "_hold"},        bus.result_o,            exp_res);
    endtask

    initial begin
        int seen;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        check("reset_valid",  32'(bus.result_valid_o), 32'd0);
        check("reset_stall",  32'(bus.stallreq_o),     32'd0);
        check("reset_result", bus.result_o,            32'd0);
        check("reset_rd",     32'(bus.rd_o),           32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Normal ops: 33-cycle latency
        run_vec("mul",    INST_MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33);
        run_vec("mulhu",  INST_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33);
        run_vec("mulh",   INST_MULH,   32'h80000000, 32'h80000000, 5'd3,  32'h40000000, 33);
        run_vec("mulhsu", INST_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, 33);
        run_vec("div",    INST_DIV,    32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33);
        run_vec("rem",    INST_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33);
        run_vec("divu",   INST_DIVU,   32'd100,      32'd7,        5'd7,  32'd14,       33);
        run_vec("remu",   INST_REMU,   32'd100,      32'd7,        5'd8,  32'd2,        33);

        // Special cases: beat in cycle 1
        run_vec("divu_z", INST_DIVU,   32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1);
        run_vec("remu_z", INST_REMU,   32'd5,        32'd0,        5'd10, 32'd5,        1);
        run_vec("div_z",  INST_DIV,    32'hFFFFFFFB, 32'd0,        5'd11, 32'hFFFFFFFF, 1);
        run_vec("div_ov", INST_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1);
        run_vec("rem_ov", INST_REM,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1);

        // Flush in BUSY cycle 10: no beat, then a fresh MUL completes normally
        @(negedge clk);
        drive_req(INST_MUL, 32'd5, 32'd6, 5'd14);
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        bus.req_i   = 1'b0;
        #1;
        check("flush_stall_now", 32'(bus.stallreq_o), 32'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        check("flush_next_valid", 32'(bus.result_valid_o), 32'd0);
        check("flush_next_stall", 32'(bus.stallreq_o),     32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.result_valid_o || bus.stallreq_o) seen++;
        end
        check("flush_no_beat", 32'(seen), 32'd0);
        run_vec("mul_after_flush", INST_MUL, 32'd3, 32'd4, 5'd15, 32'd12, 33);

        // Reset in BUSY cycle 5: everything back to zero, then a DIVU works
        @(negedge clk);
        drive_req(INST_DIV, 32'hFFFFFFF9, 32'd2, 5'd16);
        repeat (5) @(negedge clk);
        rst       = 1'b1;
        bus.req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy_valid",  32'(bus.result_valid_o), 32'd0);
        check("rst_busy_stall",  32'(bus.stallreq_o),     32'd0);
        check("rst_busy_result", bus.result_o,            32'd0);
        check("rst_busy_rd",     32'(bus.rd_o),           32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.result_valid_o || bus.stallreq_o) seen++;
        end
        check("rst_no_beat", 32'(seen), 32'd0);
        run_vec("divu_after_rst", INST_DIVU, 32'd9, 32'd3, 5'd17, 32'd3, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
